// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP RGB565 camera-side transmitter.
//   CNT_W           : width of every timing counter and timing parameter
//   HIGH_BYTE_FIRST : 1 = pixel[15:8] goes out on the bus before pixel[7:0]
//   dvp_state_e     : frame timing states
package dvp_tx_pkg;

    localparam int unsigned CNT_W           = 16;
    localparam bit          HIGH_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } dvp_state_e;

endpackage

// File: rtl/dvp_tx_timing.sv
// Frame timing generator for the DVP transmitter: state machine plus
// cycle / pixel / line counters and the byte phase bit.
//   clk, rstn : byte clock, synchronous active-low reset
//   enable    : start a frame from IDLE, or chain a new one after VFRONT
//   state     : current timing state
//   phase     : byte phase inside ACTIVE (0 = first byte of a pixel)
//   first     : first cycle of the current state
//   last      : last cycle of the current state
module dvp_tx_timing
    import dvp_tx_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMAGE_SIZE_H   = 16'd256,
    parameter logic [CNT_W-1:0] IMAGE_SIZE_V   = 16'd384,
    parameter logic [CNT_W-1:0] H_BLANK_CYCLES = 16'd64,
    parameter logic [CNT_W-1:0] VSYNC_CYCLES   = 16'd512,
    parameter logic [CNT_W-1:0] V_BACK_CYCLES  = 16'd256,
    parameter logic [CNT_W-1:0] V_FRONT_CYCLES = 16'd256
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    output dvp_state_e state,
    output logic       phase,
    output logic       first,
    output logic       last
);

    localparam logic [CNT_W-1:0] ONE = 1;

    dvp_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cyc_cnt_q,  cyc_cnt_d;
    logic [CNT_W-1:0] pix_cnt_q,  pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             phase_q,    phase_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cyc_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Output strobes. ACTIVE ends on the second byte of the last pixel;
    // pix_cnt is used there so lines longer than the cycle counter still work.
    always_comb begin
        last = 1'b0;
        case (state_q)
            ST_VSYNC:  last = (cyc_cnt_q == VSYNC_CYCLES - ONE);
            ST_VBACK:  last = (cyc_cnt_q == V_BACK_CYCLES - ONE);
            ST_ACTIVE: last = (pix_cnt_q == IMAGE_SIZE_H - ONE) && phase_q;
            ST_HBLANK: last = (cyc_cnt_q == H_BLANK_CYCLES - ONE);
            ST_VFRONT: last = (cyc_cnt_q == V_FRONT_CYCLES - ONE);
            default:   last = 1'b0;
        endcase
        first = (state_q != ST_IDLE) && (cyc_cnt_q == '0) && (pix_cnt_q == '0);
        state = state_q;
        phase = phase_q;
    end

    // Next-state and counter update
    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q + ONE;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        phase_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cyc_cnt_d = '0;
                if (enable) state_d = ST_VSYNC;
            end
            ST_VSYNC: begin
                if (last) state_d = ST_VBACK;
            end
            ST_VBACK: begin
                if (last) begin
                    state_d    = ST_ACTIVE;
                    line_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                phase_d = ~phase_q;
                if (phase_q) pix_cnt_d = pix_cnt_q + ONE;
                if (last) begin
                    pix_cnt_d = '0;
                    if (line_cnt_q == IMAGE_SIZE_V - ONE) begin
                        state_d = ST_VFRONT;
                    end else begin
                        state_d    = ST_HBLANK;
                        line_cnt_d = line_cnt_q + ONE;
                    end
                end
            end
            ST_HBLANK: begin
                if (last) state_d = ST_ACTIVE;
            end
            ST_VFRONT: begin
                if (last) state_d = enable ? ST_VSYNC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (last) cyc_cnt_d = '0;
    end

endmodule

// File: rtl/dvp_rgb565_transmitter.sv
// DVP camera-side transmitter: pulls RGB565 pixels from a valid/ready
// source and emits OV5640-style vsync / href / 8-bit data.
//   i_clk_pixel    : byte clock, forwarded as o_camera_pclk
//   i_rstn         : synchronous active-low reset
//   i_enable       : frames are generated while high
//   i_pixel_data   : RGB565 pixel {R5,G6,B5}
//   i_pixel_valid  : upstream pixel available
//   o_pixel_ready  : pixel accepted when ready & valid
//   o_camera_*     : registered vsync, href (hsync) and data bus
//   o_frame_start  : one-cycle pulse in the first VSYNC cycle
//   o_underflow    : sticky, a pixel slot found no valid pixel this frame
module dvp_rgb565_transmitter
    import dvp_tx_pkg::*;
#(
    parameter logic [CNT_W-1:0] IMAGE_SIZE_H   = 16'd256,
    parameter logic [CNT_W-1:0] IMAGE_SIZE_V   = 16'd384,
    parameter logic [CNT_W-1:0] H_BLANK_CYCLES = 16'd64,
    parameter logic [CNT_W-1:0] VSYNC_CYCLES   = 16'd512,
    parameter logic [CNT_W-1:0] V_BACK_CYCLES  = 16'd256,
    parameter logic [CNT_W-1:0] V_FRONT_CYCLES = 16'd256
) (
    input  logic        i_clk_pixel,
    input  logic        i_rstn,
    input  logic        i_enable,
    input  logic [15:0] i_pixel_data,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    output logic        o_camera_pclk,
    output logic        o_camera_vsync,
    output logic        o_camera_hsync,
    output logic [7:0]  o_camera_data,
    output logic        o_frame_start,
    output logic        o_underflow
);

    dvp_state_e state;
    logic       phase;
    logic       first;
    logic       last;

    dvp_tx_timing #(
        .IMAGE_SIZE_H  (IMAGE_SIZE_H),
        .IMAGE_SIZE_V  (IMAGE_SIZE_V),
        .H_BLANK_CYCLES(H_BLANK_CYCLES),
        .VSYNC_CYCLES  (VSYNC_CYCLES),
        .V_BACK_CYCLES (V_BACK_CYCLES),
        .V_FRONT_CYCLES(V_FRONT_CYCLES)
    ) u_timing (
        .clk   (i_clk_pixel),
        .rstn  (i_rstn),
        .enable(i_enable),
        .state (state),
        .phase (phase),
        .first (first),
        .last  (last)
    );

    logic [15:0] pix_q,      pix_d;
    logic        vsync_q,    vsync_d;
    logic        hsync_q,    hsync_d;
    logic [7:0]  data_q,     data_d;
    logic        underflow_q, underflow_d;

    logic        take;
    logic [15:0] slot_pixel;

    function automatic logic [7:0] first_byte(input logic [15:0] p);
        return HIGH_BYTE_FIRST ? p[15:8] : p[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] p);
        return HIGH_BYTE_FIRST ? p[7:0] : p[15:8];
    endfunction

    always_ff @(posedge i_clk_pixel) begin
        if (!i_rstn) begin
            pix_q       <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            data_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            data_q      <= data_d;
            underflow_q <= underflow_d;
        end
    end

    // A missing pixel becomes black; timing never stalls on the source.
    always_comb begin
        take       = (state == ST_ACTIVE) && !phase;
        slot_pixel = i_pixel_valid ? i_pixel_data : '0;

        pix_d = pix_q;
        if (take) begin
            pix_d = slot_pixel;
        end else if ((state == ST_ACTIVE) && last) begin
            pix_d = '0;
        end

        underflow_d = underflow_q;
        if ((state == ST_VSYNC) && first) begin
            underflow_d = 1'b0;
        end else if (take && !i_pixel_valid) begin
            underflow_d = 1'b1;
        end

        vsync_d = (state == ST_VSYNC);
        hsync_d = (state == ST_ACTIVE);
        data_d  = '0;
        if (state == ST_ACTIVE) begin
            // First byte comes straight from the bus so it leaves one cycle
            // after acceptance; the second byte comes from the latch.
            data_d = phase ? second_byte(pix_q) : first_byte(slot_pixel);
        end
    end

    assign o_pixel_ready  = take;
    assign o_frame_start  = (state == ST_VSYNC) && first;
    assign o_camera_pclk  = i_clk_pixel;
    assign o_camera_vsync = vsync_q;
    assign o_camera_hsync = hsync_q;
    assign o_camera_data  = data_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_dvp_rgb565_transmitter.sv
module tb_dvp_rgb565_transmitter;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int HB  = 3;
    localparam int VS  = 5;
    localparam int VB  = 2;
    localparam int VF  = 2;
    localparam int FRAME_LEN = VS + VB + V * 2 * H + (V - 1) * HB + VF;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic        i_enable;
    logic [15:0] i_pixel_data;
    logic        i_pixel_valid;
    logic        o_pixel_ready;
    logic        o_camera_pclk;
    logic        o_camera_vsync;
    logic        o_camera_hsync;
    logic [7:0]  o_camera_data;
    logic        o_frame_start;
    logic        o_underflow;

    dvp_rgb565_transmitter #(
        .IMAGE_SIZE_H  (16'(H)),
        .IMAGE_SIZE_V  (16'(V)),
        .H_BLANK_CYCLES(16'(HB)),
        .VSYNC_CYCLES  (16'(VS)),
        .V_BACK_CYCLES (16'(VB)),
        .V_FRONT_CYCLES(16'(VF))
    ) dut (
        .i_clk_pixel   (clk),
        .i_rstn        (i_rstn),
        .i_enable      (i_enable),
        .i_pixel_data  (i_pixel_data),
        .i_pixel_valid (i_pixel_valid),
        .o_pixel_ready (o_pixel_ready),
        .o_camera_pclk (o_camera_pclk),
        .o_camera_vsync(o_camera_vsync),
        .o_camera_hsync(o_camera_hsync),
        .o_camera_data (o_camera_data),
        .o_frame_start (o_frame_start),
        .o_underflow   (o_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fs_count = 0;
    logic [15:0] exp_q[$];
    logic rst_sampled = 1'b1;

    always @(posedge clk) rst_sampled <= !i_rstn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference frame: offset k counted from the first VSYNC cycle.
    function automatic bit m_active(input int k);
        int a;
        int l;
        int r;
        a = k - (VS + VB);
        if (k < 0 || a < 0) return 1'b0;
        l = a / (2 * H + HB);
        r = a % (2 * H + HB);
        return (l < V) && (r < 2 * H);
    endfunction

    function automatic bit m_ready(input int k);
        int a;
        a = k - (VS + VB);
        return m_active(k) && ((a % (2 * H + HB)) % 2 == 0);
    endfunction

    function automatic bit m_hsync(input int k);
        return (k >= 1) && m_active(k - 1);
    endfunction

    function automatic bit m_vsync(input int k);
        return (k >= 1) && (k <= VS);
    endfunction

    // Source: offers pixels; every accepted slot pushes what a receiver
    // should reassemble (the pixel, or black when no pixel was offered).
    initial begin : source
        int frame_id;
        int slot;
        int pix_idx;
        logic [15:0] cur;
        bit v;
        frame_id = 0;
        slot = 0;
        pix_idx = 0;
        cur = 16'h1234;
        i_pixel_valid = 1'b0;
        i_pixel_data = '0;
        forever begin
            @(negedge clk);
            if (o_frame_start) begin
                frame_id++;
                slot = 0;
            end
            if (o_pixel_ready && i_rstn) begin
                v = 1'b1;
                if (frame_id == 2 && slot == 2) v = 1'b0;
                if ((frame_id == 4 || frame_id == 5) && $urandom_range(0, 5) == 0) v = 1'b0;
                slot++;
                i_pixel_valid = v;
                if (v) begin
                    i_pixel_data = cur;
                    exp_q.push_back(cur);
                    pix_idx++;
                    cur = (pix_idx == 1) ? 16'h5678 : 16'($urandom);
                end else begin
                    i_pixel_data = 16'($urandom);
                    exp_q.push_back(16'h0000);
                end
            end else begin
                i_pixel_valid = 1'($urandom_range(0, 1));
                i_pixel_data = 16'($urandom);
            end
        end
    end

    // Monitor: receiver model plus frame timing reference.
    initial begin : monitor
        int pos;
        int ready_cnt;
        bit have_hi;
        logic [7:0] hi;
        logic [15:0] got;
        logic uf_exp;
        logic fs_exp;
        bit e_r;
        pos = -1;
        ready_cnt = 0;
        have_hi = 1'b0;
        hi = '0;
        uf_exp = 1'b0;
        fs_exp = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_sampled) begin
                check("reset_outputs",
                      {19'd0, o_camera_vsync, o_camera_hsync, o_camera_data,
                       o_pixel_ready, o_frame_start, o_underflow}, 32'd0);
                pos = -1;
                ready_cnt = 0;
                have_hi = 1'b0;
                exp_q.delete();
                uf_exp = 1'b0;
                fs_exp = i_rstn && i_enable;
                continue;
            end
            check("frame_start", 32'(o_frame_start), 32'(fs_exp));
            if (o_frame_start) begin
                pos = 0;
                fs_count++;
                ready_cnt = 0;
            end else if (pos >= 0 && pos < FRAME_LEN - 1) begin
                pos++;
            end else begin
                pos = -1;
            end
            e_r = m_ready(pos);
            check("vsync", 32'(o_camera_vsync), 32'(m_vsync(pos)));
            check("hsync", 32'(o_camera_hsync), 32'(m_hsync(pos)));
            check("ready", 32'(o_pixel_ready), 32'(e_r));
            check("underflow", 32'(o_underflow), 32'(uf_exp));
            if (o_pixel_ready) ready_cnt++;
            if (pos == FRAME_LEN - 1) check("ready_per_frame", 32'(ready_cnt), 32'(H * V));
            if (o_camera_hsync) begin
                if (!have_hi) begin
                    hi = o_camera_data;
                    have_hi = 1'b1;
                end else begin
                    have_hi = 1'b0;
                    got = {hi, o_camera_data};
                    if (exp_q.size() == 0) begin
                        check("pixel_unexpected", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        check("pixel", 32'(got), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                check("data_idle_zero", 32'(o_camera_data), 32'd0);
            end
            if (!i_rstn) uf_exp = 1'b0;
            else if (pos == 0) uf_exp = 1'b0;
            else if (e_r && !i_pixel_valid) uf_exp = 1'b1;
            fs_exp = (pos == -1 || pos == FRAME_LEN - 1) && i_rstn && i_enable;
        end
    end

    task automatic wait_frames(input int n);
        int budget;
        budget = 4 * FRAME_LEN + 40;
        while (fs_count < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("frame_wait_timeout", 32'(fs_count >= n), 32'd1);
    endtask

    initial begin : main
        i_rstn = 1'b0;
        i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #2 i_rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2 i_enable = 1'b1;
        // frames 1 and 2 back to back, frame 2 has a missing pixel
        wait_frames(3);
        repeat (18) @(posedge clk);
        #2 i_enable = 1'b0;       // during line 1 of frame 3
        repeat (18) @(posedge clk);
        #2 i_enable = 1'b1;       // after ten idle cycles
        wait_frames(5);
        repeat (10) @(posedge clk);
        #2 i_rstn = 1'b0;         // mid ACTIVE of frame 5
        repeat (3) @(posedge clk);
        #2 i_rstn = 1'b1;
        wait_frames(7);
        repeat (3) @(posedge clk);
        #2 i_enable = 1'b0;
        repeat (FRAME_LEN + 15) @(posedge clk);
        check("frames_seen", 32'(fs_count), 32'd7);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dvp_rgb565_transmitter.md
Name: dvp_rgb565_transmitter

Overview:
- DVP camera-side transmitter: serialises RGB565 pixels into OV5640-style 8-bit parallel video (vsync, href, data).
- It is the opposite end of the existing DVP camera receive path.
- Used as a synthesizable camera emulator / loopback source. It feeds the camera interface for board bring-up without a sensor and drives bench stimulus.
- Pixels are pulled from an upstream valid/ready source, e.g. a pattern generator or FIFO.

Parameters:
- IMAGE_SIZE_H, 16'd256: active pixels per line; each pixel is 2 bytes on the bus.
- IMAGE_SIZE_V, 16'd384: active lines per frame.
- H_BLANK_CYCLES, 16'd64: href-low cycles between active lines.
- VSYNC_CYCLES, 16'd512: vsync-high cycles at frame start.
- V_BACK_CYCLES, 16'd256: idle cycles between vsync fall and the first line.
- V_FRONT_CYCLES, 16'd256: idle cycles after the last line.
- All parameters must be ≥1.

Ports:
- i_clk_pixel  in  1  byte clock (camera pclk rate); o_camera_pclk is this clock forwarded.
- i_rstn  in  1  reset.
- i_enable  in  1  level; frames are generated while high.
- i_pixel_data  in  16  RGB565 pixel {R5,G6,B5}.
- i_pixel_valid  in  1  upstream pixel available.
- o_pixel_ready  out  1  pixel accepted this cycle when ready&valid.
- o_camera_vsync  out  1  frame sync, active high.
- o_camera_hsync  out  1  href, high during active bytes.
- o_camera_data  out  8  byte bus.
- o_frame_start  out  1  one-cycle pulse on VSYNC entry.
- o_underflow  out  1  sticky: a pixel slot found valid low this frame.

Behaviour:
- Clocking/reset: one clock, i_clk_pixel. Reset is synchronous and active-low on i_rstn.
- While i_rstn=0: state=IDLE, counters=0, and all outputs=0 (vsync, hsync, data, ready, frame_start, underflow). Reset mid-frame aborts the frame immediately, with no completion.
- States: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT. Counters are 16 bits: cyc_cnt, pix_cnt, line_cnt, plus a byte phase bit.
- IDLE: if i_enable=1, go to VSYNC next cycle.
- VSYNC:
  - Lasts VSYNC_CYCLES cycles.
  - o_frame_start pulses in the first VSYNC cycle.
  - o_underflow clears in the first VSYNC cycle.
  - Then go to VBACK.
- VBACK: lasts V_BACK_CYCLES cycles, then ACTIVE with line_cnt=0.
- ACTIVE:
  - Lasts 2*IMAGE_SIZE_H cycles; phase alternates 0,1 starting at 0.
  - o_pixel_ready=1 exactly in phase-0 cycles. It is 0 in every other state and in phase 1.
  - In a phase-0 cycle with i_pixel_valid=1: latch i_pixel_data.
  - In a phase-0 cycle with i_pixel_valid=0: latch 16'h0000 and set o_underflow. Timing never stalls.
  - After the last byte: if line_cnt=IMAGE_SIZE_V-1, go to VFRONT. Otherwise go to HBLANK and increment line_cnt.
- HBLANK: lasts H_BLANK_CYCLES cycles, then ACTIVE.
- VFRONT: lasts V_FRONT_CYCLES cycles, then VSYNC if i_enable=1, else IDLE.
- Output registration:
  - vsync, hsync and data are registered, one cycle after the state cycle that produces them.
  - A pixel accepted at cycle t gives hsync=1 and data=pixel[15:8] at t+1, then hsync=1 and data=pixel[7:0] at t+2.
  - Data=8'h00 whenever hsync=0.
  - vsync=1 exactly during the registered image of VSYNC.
- i_enable low mid-frame: the current frame completes fully, then the block goes to IDLE. i_enable high during IDLE starts VSYNC on the next cycle.
- Frame length in cycles: VSYNC + VBACK + V*2H + (V-1)*HBLANK + VFRONT.
- Upstream data is sampled only when o_pixel_ready=1. valid without ready has no effect.

Decomposition:
- Package dvp_tx_pkg holds:
  - the state enum (IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT);
  - the counter width constant CNT_W=16;
  - the byte-order constant HIGH_BYTE_FIRST.
- Sub-module dvp_tx_timing: the state machine plus counters. It outputs state, phase, first-cycle and last-cycle strobes.
- The top level holds the pixel latch, output registers and underflow flag.

Test Plan (params H=4, V=2, H_BLANK=3, VSYNC=5, VBACK=2, VFRONT=2; frame = 28 cycles):
- Reset then i_enable=1, valid always high, pixels 16'h1234, 16'h5678, … → frame_start pulse 1 cycle after enable.
  - vsync high 5 cycles.
  - hsync high 8 cycles, low 3, high 8.
  - Bytes 12,34,56,78,… in order.
  - Next frame_start exactly 28 cycles after the previous one.
- i_pixel_valid=0 on the 3rd pixel slot of line 0 → data bytes 00,00 for that pixel.
  - o_underflow=1 from the next cycle until the next frame's VSYNC entry.
  - Line timing unchanged.
- Drop i_enable during line 1 → that frame completes all 28 cycles, then outputs stay 0 and ready stays 0 in IDLE.
- Reassert i_enable after 10 idle cycles → frame_start on the next cycle.
- Assert i_rstn=0 during ACTIVE → every output is 0 on the next edge. After release with enable=1, a full clean frame starts.
- Check o_pixel_ready count per frame = H*V = 8 and pulse spacing = 2 within a line.
  - Scoreboard vs. a receiver model that reassembles RGB565 (high byte first).
  - Reassembled pixels match the source sequence exactly.
